keypad_matrix_scanner: RTL and testbench

- Scans a 4x4 active-low matrix keypad, debounces it, and produces the 16-bit one-hot key word with a level valid that feeds the keypad input-accumulation stage.
- key_valid rises once per physical press and stays high with key_value stable while the key is held. It drops to 0 for at least one full frame between presses, so the downstream rising-edge capture sees exactly one event per press.
- Ghosting (more than one key down at once) is never reported.

---
 rtl/keypad_matrix_scanner.sv | 197 +++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: column drive, row sync, frame capture,
// press/release debounce and a registered one-hot key word with a level valid.
module keypad_matrix_scanner #(
    parameter int unsigned SCAN_DIV       = 2500,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] key_value,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        press_pulse
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0]  DEB_N = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEB_PRESS,
        ST_PRESSED,
        ST_DEB_REL
    } state_e;

    logic [3:0]       row_s1_q, row_s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       col_out_q, col_out_d;
    logic [15:0]      frame_q, frame_d;
    state_e           state_q, state_d;
    logic [15:0]      cand_q, cand_d;
    logic [3:0]       deb_q, deb_d;
    logic [15:0]      key_value_q, key_value_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             press_pulse_q, press_pulse_d;

    logic             tick_c, frame_done_c, single_c;
    logic [15:0]      frame_full_c;
    logic [3:0]       deb_inc_c;
    logic             enter_press_c, go_idle_c;

    // Binary index of a one-hot word (0 for an all-zero word).
    function automatic logic [3:0] onehot_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

    // Two-flop row synchronizer; idle rows read as all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q <= 4'b1111;
            row_s2_q <= 4'b1111;
        end else begin
            row_s1_q <= row_in;
            row_s2_q <= row_s1_q;
        end
    end

    // Dwell counter, column sequencing and frame accumulation.
    always_comb begin
        tick_c       = (cnt_q == CNT_W'(SCAN_DIV - 1));
        frame_done_c = tick_c && (col_q == 2'd3);
        frame_full_c = frame_q;
        for (int r = 0; r < 4; r++) begin
            frame_full_c[{2'(r), col_q}] = ~row_s2_q[r];
        end
        single_c  = (frame_full_c != 16'h0) && ((frame_full_c & (frame_full_c - 16'h1)) == 16'h0);

        cnt_d     = tick_c ? '0 : cnt_q + CNT_W'(1);
        col_d     = tick_c ? col_q + 2'd1 : col_q;
        col_out_d = ~(4'b0001 << col_d);
        frame_d   = frame_q;
        if (tick_c) frame_d = frame_done_c ? 16'h0 : frame_full_c;
    end

    // Debounce FSM next-state and registered key outputs; evaluates only on frame completion.
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        deb_d         = deb_q;
        key_value_d   = key_value_q;
        key_valid_d   = key_valid_q;
        key_code_d    = key_code_q;
        press_pulse_d = 1'b0;
        enter_press_c = 1'b0;
        go_idle_c     = 1'b0;
        deb_inc_c     = (deb_q >= DEB_N) ? deb_q : deb_q + 4'd1;

        if (frame_done_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (single_c) begin
                        cand_d = frame_full_c;
                        deb_d  = 4'd1;
                        if (DEBOUNCE_SCANS == 1) enter_press_c = 1'b1;
                        else                     state_d = ST_DEB_PRESS;
                    end
                end
                ST_DEB_PRESS: begin
                    if (frame_full_c == cand_q) begin
                        deb_d = deb_inc_c;
                        if (deb_inc_c >= DEB_N) enter_press_c = 1'b1;
                    end else if (single_c) begin
                        cand_d = frame_full_c;
                        deb_d  = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        cand_d  = 16'h0;
                        deb_d   = 4'd0;
                    end
                end
                ST_PRESSED: begin
                    if (frame_full_c != cand_q) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            go_idle_c = 1'b1;
                        end else begin
                            state_d = ST_DEB_REL;
                            deb_d   = 4'd1;
                        end
                    end
                end
                ST_DEB_REL: begin
                    if (frame_full_c == cand_q) begin
                        state_d = ST_PRESSED;
                        deb_d   = 4'd0;
                    end else begin
                        deb_d = deb_inc_c;
                        if (deb_inc_c >= DEB_N) go_idle_c = 1'b1;
                    end
                end
                default: begin
                    go_idle_c = 1'b1;
                end
            endcase
        end

        if (enter_press_c) begin
            state_d       = ST_PRESSED;
            deb_d         = 4'd0;
            key_value_d   = cand_d;
            key_code_d    = onehot_index(cand_d);
            key_valid_d   = 1'b1;
            press_pulse_d = 1'b1;
        end
        if (go_idle_c) begin
            state_d     = ST_IDLE;
            cand_d      = 16'h0;
            deb_d       = 4'd0;
            key_value_d = 16'h0;
            key_code_d  = 4'd0;
            key_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            col_q         <= 2'd0;
            col_out_q     <= 4'b1110;
            frame_q       <= 16'h0;
            state_q       <= ST_IDLE;
            cand_q        <= 16'h0;
            deb_q         <= 4'd0;
            key_value_q   <= 16'h0;
            key_valid_q   <= 1'b0;
            key_code_q    <= 4'd0;
            press_pulse_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            col_q         <= col_d;
            col_out_q     <= col_out_d;
            frame_q       <= frame_d;
            state_q       <= state_d;
            cand_q        <= cand_d;
            deb_q         <= deb_d;
            key_value_q   <= key_value_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            press_pulse_q <= press_pulse_d;
        end
    end

    assign col_out     = col_out_q;
    assign key_value   = key_value_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign press_pulse = press_pulse_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner with a frame-level press/release model.
module tb_keypad_matrix_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] key_value;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        press_pulse;
    logic [15:0] keys = 16'h0;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: held key and consecutive-frame counters.
    bit          m_held;
    logic [15:0] m_key;
    logic [15:0] m_last;
    int          m_run;
    int          m_miss;
    bit          m_pulse;

    keypad_matrix_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_value(key_value), .key_valid(key_valid), .key_code(key_code),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    // Keypad: row r pulled low when a driven (low) column has key (r,c) down.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
        end
    end

    function automatic logic [21:0] expected();
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 16; i++) if (m_key[i]) code = 4'(i);
        return {m_held, m_key, code, m_pulse};
    endfunction

    task automatic model_reset();
        m_held = 0; m_key = 16'h0; m_last = 16'h0; m_run = 0; m_miss = 0; m_pulse = 0;
    endtask

    // One completed frame: a run of DEB identical single-key frames seen while
    // nothing is held presses; DEB consecutive frames differing from the held key release.
    task automatic model_frame(input logic [15:0] f);
        m_pulse = 0;
        if (!m_held) begin
            if ($countones(f) == 1) begin
                if (m_run > 0 && f == m_last) m_run++;
                else m_run = 1;
                m_last = f;
            end else begin
                m_run = 0;
            end
            if (m_run == DEB) begin
                m_held = 1; m_key = f; m_pulse = 1; m_run = 0; m_miss = 0;
            end
        end else begin
            if (f == m_key) m_miss = 0;
            else m_miss++;
            if (m_miss == DEB) begin
                m_held = 0; m_key = 16'h0; m_miss = 0; m_run = 0;
            end
        end
    endtask

    // Hold a key set for one whole frame, sampling just after its completing edge.
    task automatic step_frame(input logic [15:0] f);
        keys = f;
        repeat (FRAME) @(posedge clk);
        #1;
        model_frame(f);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        keys = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({col_out, key_valid, key_value, key_code, press_pulse} !== {4'b1110, 1'b0, 16'h0, 4'h0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset: got col=%b valid=%b value=%h code=%h pulse=%b, want col=1110 and zeros",
                     col_out, key_valid, key_value, key_code, press_pulse);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_col;
        for (int k = 1; k <= 4 * int'(FRAME); k++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            compared++;
            if ({col_out, key_valid, key_value} !== {exp_col, 1'b0, 16'h0}) begin
                mismatched++;
                $display("FAIL idle_scan cyc %0d: got col=%b valid=%b value=%h, want col=%b valid=0 value=0",
                         k, col_out, key_valid, key_value, exp_col);
            end
        end
        for (int i = 0; i < 4; i++) model_frame(16'h0);
    endtask

    task automatic test_clean_press();
        for (int i = 0; i < 13; i++) begin
            if (i == 3) begin
                keys = 16'h0200;
                @(posedge clk);
                #1;
                compared++;
                if (press_pulse !== 1'b0) begin
                    mismatched++;
                    $display("FAIL clean_press pulse_width: got pulse=%b one clk later, want 0", press_pulse);
                end
                repeat (FRAME - 1) @(posedge clk);
                #1;
                model_frame(16'h0200);
            end else begin
                step_frame(i < 10 ? 16'h0200 : 16'h0000);
            end
            compared++;
            if ({key_valid, key_value, key_code, press_pulse} !== expected()) begin
                mismatched++;
                $display("FAIL clean_press frame %0d: got %b/%h/%0d/%b, want %h",
                         i, key_valid, key_value, key_code, press_pulse, expected());
            end
            if (i == 2) begin
                compared++;
                if ({key_valid, key_value, key_code, press_pulse} !== {1'b1, 16'h0200, 4'd9, 1'b1}) begin
                    mismatched++;
                    $display("FAIL clean_press accept: got %b/%h/%0d/%b, want 1/0200/9/1",
                             key_valid, key_value, key_code, press_pulse);
                end
            end
            if (i == 12) begin
                compared++;
                if ({key_valid, key_value} !== {1'b0, 16'h0}) begin
                    mismatched++;
                    $display("FAIL clean_press release: got valid=%b value=%h, want 0/0000", key_valid, key_value);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] f;
        for (int i = 0; i < 13; i++) begin
            if (i < 6)       f = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            else if (i < 10) f = 16'h0001;
            else             f = 16'h0000;
            step_frame(f);
            compared++;
            if ({key_valid, key_value, key_code, press_pulse} !== expected()) begin
                mismatched++;
                $display("FAIL bounce frame %0d: got %b/%h/%0d/%b, want %h",
                         i, key_valid, key_value, key_code, press_pulse, expected());
            end
            if (i < 8 || i == 8) begin
                compared++;
                if (key_valid !== (i == 8)) begin
                    mismatched++;
                    $display("FAIL bounce valid frame %0d: got %b, want %b", i, key_valid, (i == 8));
                end
            end
        end
    endtask

    task automatic test_ghost();
        logic [15:0] f;
        int          low_frames;
        low_frames = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 4)       f = 16'h0020;
            else if (i < 7)  f = 16'h8020;
            else if (i < 11) f = 16'h8000;
            else             f = 16'h0000;
            step_frame(f);
            compared++;
            if ({key_valid, key_value, key_code, press_pulse} !== expected()) begin
                mismatched++;
                $display("FAIL ghost frame %0d: got %b/%h/%0d/%b, want %h",
                         i, key_valid, key_value, key_code, press_pulse, expected());
            end
            if (i >= 6 && i < 9 && key_valid === 1'b0) low_frames++;
            if (i == 9) begin
                compared++;
                if ({key_valid, key_value, key_code, low_frames >= 1} !== {1'b1, 16'h8000, 4'd15, 1'b1}) begin
                    mismatched++;
                    $display("FAIL ghost rollover: got %b/%h/%0d low_frames=%0d, want 1/8000/15 low_frames>=1",
                             key_valid, key_value, key_code, low_frames);
                end
            end
        end
    endtask

    task automatic test_dropout();
        logic [15:0] f;
        int          pulses;
        pulses = 0;
        for (int i = 0; i < 11; i++) begin
            f = (i == 4 || i >= 8) ? 16'h0000 : 16'h0008;
            step_frame(f);
            if (i >= 3 && press_pulse === 1'b1) pulses++;
            compared++;
            if ({key_valid, key_value, key_code, press_pulse} !== expected()) begin
                mismatched++;
                $display("FAIL dropout frame %0d: got %b/%h/%0d/%b, want %h",
                         i, key_valid, key_value, key_code, press_pulse, expected());
            end
            if (i == 7) begin
                compared++;
                if ({key_valid, key_value, pulses} !== {1'b1, 16'h0008, 32'd0}) begin
                    mismatched++;
                    $display("FAIL dropout hold: got valid=%b value=%h extra_pulses=%0d, want 1/0008/0",
                             key_valid, key_value, pulses);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step_frame(16'h0400);
        compared++;
        if (key_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL async_reset pre: got valid=%b, want 1", key_valid);
        end
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if ({col_out, key_valid, key_value, key_code, press_pulse} !== {4'b1110, 1'b0, 16'h0, 4'h0, 1'b0}) begin
            mismatched++;
            $display("FAIL async_reset immediate: got col=%b valid=%b value=%h code=%h pulse=%b, want 1110 and zeros",
                     col_out, key_valid, key_value, key_code, press_pulse);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 7; i++) begin
            step_frame(i < 3 ? 16'h0400 : 16'h0000);
            compared++;
            if ({key_valid, key_value, key_code, press_pulse} !== expected()) begin
                mismatched++;
                $display("FAIL async_reset frame %0d: got %b/%h/%0d/%b, want %h",
                         i, key_valid, key_value, key_code, press_pulse, expected());
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] f;
        int          r;
        f = 16'h0;
        for (int i = 0; i < 64; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)      f = f;
            else if (r < 7) f = 16'h0;
            else if (r < 9) f = 16'h1 << $urandom_range(0, 15);
            else            f = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            if (i >= 60) f = 16'h0;
            step_frame(f);
            compared++;
            if ({key_valid, key_value, key_code, press_pulse} !== expected()) begin
                mismatched++;
                $display("FAIL random frame %0d keys=%h: got %b/%h/%0d/%b, want %h",
                         i, f, key_valid, key_value, key_code, press_pulse, expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_clean_press();
        test_bounce();
        test_ghost();
        test_dropout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
